// File: rtl/vga_pkg.sv
// vga_pkg: shared timing defaults, mode enums and colour helper for the camera-to-VGA bridge
package vga_pkg;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    typedef enum logic {PIX_RGB565 = 1'b0, PIX_Y8 = 1'b1} pix_fmt_e;
    typedef enum logic {WAIT_VS = 1'b0, RUN = 1'b1} bridge_state_e;

    function automatic logic [23:0] rgb565_to_888(input logic [15:0] w);
        return {w[15:11], w[15:13], w[10:5], w[10:9], w[4:0], w[4:2]};
    endfunction
endpackage

// File: rtl/cam_line_fifo.sv
// cam_line_fifo: single-clock pixel FIFO with registered read and synchronous flush
module cam_line_fifo #(
    parameter int DEPTH = 1024,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr, rptr;
    logic         do_push, do_pop;

    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty   = wptr == rptr;
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty;

    // storage array needs no reset
    always_ff @(posedge clk)
        if (do_push) mem[wptr[AW-1:0]] <= wdata;

    // pointers and registered read port; flush wins over a same-cycle push
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            rdata <= '0;
        end else begin
            if (do_pop) rdata <= mem[rptr[AW-1:0]];
            if (flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (do_push) wptr <= wptr + (AW+1)'(1);
                if (do_pop) rptr <= rptr + (AW+1)'(1);
            end
        end
    end
endmodule

// File: rtl/cam_vga_bridge.sv
// cam_vga_bridge: OV7670 byte stream to VGA through a line FIFO, raster frame-locked to camera VSYNC
module cam_vga_bridge
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int H_FP       = VGA_H_FP,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BP       = VGA_H_BP,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int V_FP       = VGA_V_FP,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BP       = VGA_V_BP,
    parameter bit SYNC_POL   = 1'b0,
    parameter bit CAM_VS_POL = 1'b1,
    parameter int FIFO_DEPTH = 1024
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       cam_xclk,
    input  logic       cam_href,
    input  logic       cam_vsync,
    input  logic [7:0] cam_data,
    input  logic       pix_fmt,
    input  logic       byte_swap,
    input  logic       clear_status,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_n,
    output logic       VGA_SYNC_n,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       locked,
    output logic       overflow,
    output logic       underflow,
    output logic       frame_slip
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    bridge_state_e state;
    pix_fmt_e      fmt_a;
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          vs_q, vs_on, vs_edge, vs_fall;
    logic          phase, swap_a, push, full, empty;
    logic          active, hs_on, vt_on;
    logic          act1, val1, hs1, vs1;
    logic [7:0]    b0;
    logic [15:0]   word, rdata;

    assign cam_xclk   = clk;
    assign VGA_CLK    = clk;
    assign VGA_SYNC_n = 1'b1;
    assign vs_on      = cam_vsync == CAM_VS_POL;
    assign vs_edge    = vs_on && !vs_q;
    assign vs_fall    = !vs_on && vs_q;
    assign push       = cam_href && phase;
    assign word       = swap_a ? {cam_data, b0} : {b0, cam_data};
    assign active     = state == RUN && h < HW'(H_ACTIVE) && v < VW'(V_ACTIVE);
    assign hs_on      = h >= HW'(H_ACTIVE + H_FP) && h < HW'(H_ACTIVE + H_FP + H_SYNC);
    assign vt_on      = v >= VW'(V_ACTIVE + V_FP) && v < VW'(V_ACTIVE + V_FP + V_SYNC);

    cam_line_fifo #(.DEPTH(FIFO_DEPTH), .W(16)) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .flush  (vs_edge),
        .push   (push),
        .wdata  (word),
        .pop    (active),
        .rdata  (rdata),
        .full   (full),
        .empty  (empty)
    );

    // vsync edge tracking, byte pairing and per-frame mode latch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_q   <= 1'b0;
            phase  <= 1'b0;
            b0     <= '0;
            fmt_a  <= PIX_RGB565;
            swap_a <= 1'b0;
        end else begin
            vs_q  <= vs_on;
            phase <= cam_href && !phase;
            if (cam_href && !phase) b0 <= cam_data;
            if (vs_edge) begin
                fmt_a  <= pix_fmt_e'(pix_fmt);
                swap_a <= byte_swap;
            end
        end
    end

    // frame-lock state machine and raster counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= WAIT_VS;
            locked <= 1'b0;
            h      <= '0;
            v      <= '0;
        end else if (state == WAIT_VS) begin
            h <= '0;
            v <= '0;
            if (vs_fall) begin
                state  <= RUN;
                locked <= 1'b1;
            end
        end else begin
            h <= h == HW'(H_TOTAL - 1) ? '0 : h + HW'(1);
            if (h == HW'(H_TOTAL - 1)) v <= v == VW'(V_TOTAL - 1) ? '0 : v + VW'(1);
        end
    end

    // two-stage output pipeline: FIFO read stage, then colour expansion
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act1        <= 1'b0;
            val1        <= 1'b0;
            hs1         <= 1'b0;
            vs1         <= 1'b0;
            VGA_HS      <= ~SYNC_POL;
            VGA_VS      <= ~SYNC_POL;
            VGA_BLANK_n <= 1'b0;
            {VGA_R, VGA_G, VGA_B} <= '0;
        end else begin
            act1        <= active;
            val1        <= active && !empty;
            hs1         <= hs_on;
            vs1         <= vt_on;
            VGA_HS      <= hs1 ? SYNC_POL : ~SYNC_POL;
            VGA_VS      <= vs1 ? SYNC_POL : ~SYNC_POL;
            VGA_BLANK_n <= act1;
            {VGA_R, VGA_G, VGA_B} <= !(act1 && val1) ? '0 :
                                     fmt_a == PIX_Y8 ? {3{rdata[15:8]}} : rgb565_to_888(rdata);
        end
    end

    // sticky status flags; a same-cycle event beats clear_status
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            frame_slip <= 1'b0;
        end else begin
            overflow   <= (push && full && !vs_edge) || (overflow && !clear_status);
            underflow  <= (active && empty) || (underflow && !clear_status);
            frame_slip <= (vs_edge && state == RUN && v < VW'(V_ACTIVE)) || (frame_slip && !clear_status);
        end
    end
endmodule

// File: tb/tb_cam_vga_bridge.sv
// tb_cam_vga_bridge: directed and random stimulus against a queue-based reference of the bridge
module tb_cam_vga_bridge;
    localparam int HA = 8, HF = 2, HSY = 3, HB = 3;
    localparam int VA = 6, VF = 1, VSY = 2, VB = 2;
    localparam int DEPTH = 4;
    localparam int HT = HA + HF + HSY + HB;
    localparam int VT = VA + VF + VSY + VB;

    logic       clk = 0, reset_n = 1;
    logic       cam_href = 0, cam_vsync = 0, pix_fmt = 0, byte_swap = 0, clear_status = 0;
    logic [7:0] cam_data = 0;
    logic       cam_xclk, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       locked, overflow, underflow, frame_slip;

    int n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    cam_vga_bridge #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .SYNC_POL(1'b0), .CAM_VS_POL(1'b1), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cam_xclk(cam_xclk),
        .cam_href(cam_href), .cam_vsync(cam_vsync), .cam_data(cam_data),
        .pix_fmt(pix_fmt), .byte_swap(byte_swap), .clear_status(clear_status),
        .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_BLANK_n(VGA_BLANK_n), .VGA_SYNC_n(VGA_SYNC_n),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .locked(locked), .overflow(overflow), .underflow(underflow), .frame_slip(frame_slip)
    );

    // reference model: raster position from elapsed cycles, FIFO as a queue
    typedef struct packed {logic hs, vs, blank, val; logic [15:0] w;} item_t;
    item_t       pend, cur;
    logic [15:0] q[$];
    logic [7:0]  m_b0;
    logic [23:0] e_rgb;
    bit          m_run, m_prev_vs, m_phase, m_fmt, m_swap, m_ovf, m_und, m_slip;
    bit          e_hs, e_vs, e_blank;
    int          m_n;

    function automatic logic [23:0] exp_rgb(input logic [15:0] w, input bit y);
        int r5, g6, b5;
        if (y) return {w[15:8], w[15:8], w[15:8]};
        r5 = int'(w) >> 11;
        g6 = (int'(w) >> 5) % 64;
        b5 = int'(w) % 32;
        return {8'(r5 * 8 + r5 / 4), 8'(g6 * 4 + g6 / 16), 8'(b5 * 8 + b5 / 4)};
    endfunction

    function automatic int m_h();
        return m_n % HT;
    endfunction

    function automatic int m_v();
        return (m_n / HT) % VT;
    endfunction

    always @(posedge clk or negedge reset_n) begin : model
        int h, v;
        bit act, ev, fall, push, full;
        logic [15:0] w;
        if (!reset_n) begin
            pend = '0; cur = '0; q.delete();
            m_b0 = 0; m_run = 0; m_prev_vs = 0; m_phase = 0; m_fmt = 0; m_swap = 0;
            m_ovf = 0; m_und = 0; m_slip = 0; m_n = 0;
            e_hs = 1; e_vs = 1; e_blank = 0; e_rgb = 0;
        end else begin
            h = m_h();
            v = m_v();
            act = m_run && h < HA && v < VA;
            cur = pend;
            e_hs = !cur.hs;
            e_vs = !cur.vs;
            e_blank = cur.blank;
            e_rgb = (cur.blank && cur.val) ? exp_rgb(cur.w, m_fmt) : 24'h0;
            pend.hs = m_run && h >= HA + HF && h < HA + HF + HSY;
            pend.vs = m_run && v >= VA + VF && v < VA + VF + VSY;
            pend.blank = act;
            pend.val = act && q.size() > 0;
            pend.w = pend.val ? q[0] : 16'h0;
            ev = cam_vsync && !m_prev_vs;
            fall = !cam_vsync && m_prev_vs;
            m_prev_vs = cam_vsync;
            push = 0;
            w = 0;
            if (cam_href && !m_phase) begin
                m_b0 = cam_data;
                m_phase = 1;
            end else if (cam_href) begin
                push = 1;
                w = m_swap ? {cam_data, m_b0} : {m_b0, cam_data};
                m_phase = 0;
            end else m_phase = 0;
            full = q.size() == DEPTH;
            m_und = (act && q.size() == 0) || (m_und && !clear_status);
            m_ovf = (push && full && !ev) || (m_ovf && !clear_status);
            m_slip = (ev && m_run && v < VA) || (m_slip && !clear_status);
            if (act && q.size() > 0) void'(q.pop_front());
            if (ev) begin
                q.delete();
                m_fmt = pix_fmt;
                m_swap = byte_swap;
            end else if (push && !full) q.push_back(w);
            if (m_run) m_n++;
            else if (fall) begin
                m_run = 1;
                m_n = 0;
            end
        end
    end

    task automatic chk1(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk1("hs", VGA_HS, e_hs);
        chk1("vs", VGA_VS, e_vs);
        chk1("blank_n", VGA_BLANK_n, e_blank);
        chk1("rgb", {VGA_R, VGA_G, VGA_B}, e_rgb);
        chk1("sync_n", VGA_SYNC_n, 1);
        chk1("clocks", {cam_xclk, VGA_CLK}, {clk, clk});
        chk1("locked", locked, m_run);
        chk1("overflow", overflow, m_ovf);
        chk1("underflow", underflow, m_und);
        chk1("frame_slip", frame_slip, m_slip);
    endtask

    task automatic chk_reset(input string tag);
        chk1({tag, "_hs"}, VGA_HS, 1);
        chk1({tag, "_vs"}, VGA_VS, 1);
        chk1({tag, "_blank"}, VGA_BLANK_n, 0);
        chk1({tag, "_rgb"}, {VGA_R, VGA_G, VGA_B}, 0);
        chk1({tag, "_sync_n"}, VGA_SYNC_n, 1);
        chk1({tag, "_locked"}, locked, 0);
        chk1({tag, "_flags"}, {overflow, underflow, frame_slip}, 0);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            check_all();
        end
    endtask

    task automatic send_word(input logic [7:0] a, input logic [7:0] b);
        cam_href = 1; cam_data = a; step(1);
        cam_data = b; step(1);
        cam_href = 0;
    endtask

    task automatic wait_pos(input int line, input int col);
        int i;
        for (i = 0; i < 400; i++) begin
            if (m_run && m_v() == line && m_h() == col) break;
            step(1);
        end
        if (i == 400) begin
            n_fail++;
            $display("FAIL wait_pos line=%0d col=%0d not reached", line, col);
        end
    endtask

    task automatic find_blank();
        for (int i = 0; i < 400; i++) begin
            step(1);
            if (VGA_BLANK_n === 1'b1) break;
        end
        chk1("blank_seen", VGA_BLANK_n, 1);
    endtask

    initial begin
        int first_blank, first_hs;
        logic [23:0] rgb1;
        #2 reset_n = 0;
        #1 chk_reset("rst");
        step(3);
        reset_n = 1;
        step(4);
        chk1("idle_locked", locked, 0);
        chk1("idle_hs", VGA_HS, 1);
        // lock with one RGB565 red pixel waiting
        cam_vsync = 1; step(1);
        cam_href = 1; cam_data = 8'hF8; step(1);
        cam_data = 8'h00; step(1);
        cam_href = 0; cam_vsync = 0; step(1);
        chk1("lock", locked, 1);
        first_blank = -1; first_hs = -1; rgb1 = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            if (first_blank < 0 && VGA_BLANK_n === 1'b1) begin
                first_blank = i;
                rgb1 = {VGA_R, VGA_G, VGA_B};
            end
            if (first_hs < 0 && VGA_HS === 1'b0) first_hs = i;
        end
        chk1("first_blank_cycle", first_blank, 2);
        chk1("rgb565_red", rgb1, 24'hFF0000);
        chk1("first_hs_cycle", first_hs, HA + HF + 2);
        chk1("underflow_empty", underflow, 1);
        // luma mode, then a mid-frame pix_fmt change that must not take effect
        pix_fmt = 1;
        wait_pos(VA, 0);
        cam_vsync = 1; step(1); cam_vsync = 0;
        send_word(8'h80, 8'h55);
        send_word(8'h12, 8'h34);
        pix_fmt = 0;
        find_blank();
        chk1("luma_px0", {VGA_R, VGA_G, VGA_B}, 24'h808080);
        step(1);
        chk1("luma_px1", {VGA_R, VGA_G, VGA_B}, 24'h121212);
        // byte swap
        byte_swap = 1;
        wait_pos(VA, 0);
        cam_vsync = 1; step(1); cam_vsync = 0;
        send_word(8'hF8, 8'h00);
        find_blank();
        chk1("swap_rgb", {VGA_R, VGA_G, VGA_B}, 24'h001CC6);
        // overflow, lone odd byte, set-beats-clear
        byte_swap = 0;
        wait_pos(VA, 0);
        clear_status = 1; step(1); clear_status = 0;
        chk1("clear_flags", {overflow, underflow}, 0);
        cam_href = 1; cam_data = 8'hAA; step(1);
        cam_href = 0; step(1);
        for (int i = 0; i < 5; i++) send_word(8'($urandom), 8'($urandom));
        chk1("ovf_set", overflow, 1);
        cam_href = 1; cam_data = 8'h3C; step(1);
        cam_data = 8'hC3; clear_status = 1; step(1);
        cam_href = 0; clear_status = 0;
        chk1("ovf_set_wins", overflow, 1);
        clear_status = 1; step(1); clear_status = 0;
        chk1("ovf_cleared", overflow, 0);
        // frame slip mid-frame flushes the FIFO
        wait_pos(3, 0);
        send_word(8'h55, 8'hAA);
        cam_vsync = 1; step(1); cam_vsync = 0;
        chk1("frame_slip", frame_slip, 1);
        step(HT);
        // asynchronous reset in the middle of a line
        wait_pos(4, 5);
        #3 reset_n = 0;
        #1 chk_reset("mid_rst");
        step(2);
        reset_n = 1;
        step(2);
        // random traffic with periodic frame strobes
        for (int i = 0; i < 3000; i++) begin
            cam_vsync = (i % 331) inside {[20:22]};
            cam_href = $urandom_range(0, 9) < 7;
            cam_data = 8'($urandom);
            if (i % 331 == 0) begin
                pix_fmt = 1'($urandom);
                byte_swap = 1'($urandom);
            end
            clear_status = $urandom_range(0, 49) == 0;
            step(1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
